// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage data cache (mem_stage_dcache).
package mem_pkg;

    localparam int LINE_BYTES = 4;

    typedef logic [7:0] byte_lane_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } dcache_state_t;

    function automatic logic [LINE_BYTES-1:0] sb_be(input logic [1:0] offset);
        return 4'b0001 << offset;
    endfunction

endpackage

// File: rtl/mem_stage_dcache_array.sv
// Valid/tag/data storage for the direct-mapped data cache: combinational read
// port, byte-enable write port, whole array cleared asynchronously on rst.
module dcache_array
    import mem_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int IDX_W    = $clog2(NUM_SETS),
    parameter int TAG_W    = 30 - IDX_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [IDX_W-1:0]           idx,
    output logic                       rd_valid,
    output logic [TAG_W-1:0]           rd_tag,
    output logic [LINE_BYTES-1:0][7:0] rd_data,
    input  logic                       we,
    input  logic [LINE_BYTES-1:0]      be,
    input  logic [TAG_W-1:0]           wtag,
    input  logic [LINE_BYTES-1:0][7:0] wdata
);

    logic [NUM_SETS-1:0]         valid;
    logic [TAG_W-1:0]            tag_arr  [NUM_SETS];
    byte_lane_t [LINE_BYTES-1:0] data_arr [NUM_SETS];

    assign rd_valid = valid[idx];
    assign rd_tag   = tag_arr[idx];
    assign rd_data  = data_arr[idx];

    // Writes always mark the line valid and retag it; on a store hit the tag is unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                tag_arr[s]  <= '0;
                data_arr[s] <= '0;
            end
        end else if (we) begin
            valid[idx]   <= 1'b1;
            tag_arr[idx] <= wtag;
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (be[b]) data_arr[idx][b] <= wdata[b];
            end
        end
    end

endmodule

// File: rtl/mem_stage_dcache.sv
// MEM-stage direct-mapped, write-through, no-write-allocate data cache controller.
// Define DCACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module mem_stage_dcache
    import mem_pkg::*;
#(
    parameter  int NUM_SETS = 16,
    localparam int IDX_W    = $clog2(NUM_SETS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic                       is_LB_SB,
    input  logic [31:0]                addr,
    input  logic [31:0]                wdata,
    output logic [LINE_BYTES-1:0][7:0] cache_data_out,
    output logic [1:0]                 mem_block,
    output logic                       freeze,
    output logic                       mm_req,
    output logic                       mm_we,
    output logic [31:0]                mm_addr,
    output logic [3:0]                 mm_be,
    output logic [31:0]                mm_wdata,
    input  logic [31:0]                mm_rdata,
    input  logic                       mm_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]                hit_cnt,
    output logic [31:0]                miss_cnt
`endif
);

    localparam int TAG_W = 30 - IDX_W;

    dcache_state_t state, state_next;
    logic              resume;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_BYTES-1:0][7:0] rd_data;
    logic              hit;
    logic              arr_we;
    logic [3:0]        arr_be;
    logic [31:0]       arr_wdata;
    logic [31:0]       store_data;

    assign idx        = addr[IDX_W+1:2];
    assign tag        = addr[31:IDX_W+2];
    assign hit        = rd_valid && (rd_tag == tag);
    assign store_data = is_LB_SB ? {4{wdata[7:0]}} : wdata;

    assign cache_data_out = rd_data;
    assign mem_block      = addr[1:0];
    assign mm_addr        = {addr[31:2], 2'b00};
    assign mm_wdata       = store_data;
    assign mm_be          = (state == WRITE && is_LB_SB) ? sb_be(addr[1:0]) : 4'b1111;

    dcache_array #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .idx      (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (arr_we),
        .be       (arr_be),
        .wtag     (tag),
        .wdata    (arr_wdata)
    );

    // resume marks the first IDLE cycle after a memory transaction: the stalled
    // store is still presented then and must retire instead of restarting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            resume <= 1'b0;
        end else begin
            state  <= state_next;
            resume <= (state != IDLE) && (state_next == IDLE);
        end
    end

    always_comb begin
        state_next = state;
        freeze     = 1'b0;
        mm_req     = 1'b0;
        mm_we      = 1'b0;
        arr_we     = 1'b0;
        arr_be     = 4'b1111;
        arr_wdata  = store_data;
        case (state)
            IDLE: begin
                if (mem_write) begin
                    if (!resume) begin
                        freeze     = 1'b1;
                        state_next = WRITE;
                        arr_we     = hit;
                        arr_be     = is_LB_SB ? sb_be(addr[1:0]) : 4'b1111;
                    end
                end else if (mem_read && !hit) begin
                    freeze     = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                freeze = 1'b1;
                mm_req = 1'b1;
                if (mm_ready) begin
                    arr_we     = 1'b1;
                    arr_wdata  = mm_rdata;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                freeze = 1'b1;
                mm_req = 1'b1;
                mm_we  = 1'b1;
                if (mm_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (state == IDLE && mem_read && !mem_write && hit && !resume && hit_cnt != 32'hFFFF_FFFF)
                hit_cnt <= hit_cnt + 32'd1;
            if (state == IDLE && state_next == FILL && miss_cnt != 32'hFFFF_FFFF)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Self-checking bench for mem_stage_dcache: directed scenarios plus randomized
// traffic checked against a write-through cache/memory reference model.
module tb_mem_stage_dcache;

    logic            clk;
    logic            rst;
    logic            mem_read;
    logic            mem_write;
    logic            is_LB_SB;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [3:0][7:0] cache_data_out;
    logic [1:0]      mem_block;
    logic            freeze;
    logic            mm_req;
    logic            mm_we;
    logic [31:0]     mm_addr;
    logic [3:0]      mm_be;
    logic [31:0]     mm_wdata;
    logic [31:0]     mm_rdata;
    logic            mm_ready;
`ifdef DCACHE_STATS_EN
    logic [31:0]     hit_cnt;
    logic [31:0]     miss_cnt;
`endif

    int passed = 0;
    int total  = 0;

    // Reference model: main memory by word address, and the word address
    // currently resident in each of the 16 cache lines.
    logic [31:0] mem  [int];
    int          line [int];

    mem_stage_dcache #(.NUM_SETS(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .is_LB_SB       (is_LB_SB),
        .addr           (addr),
        .wdata          (wdata),
        .cache_data_out (cache_data_out),
        .mem_block      (mem_block),
        .freeze         (freeze),
        .mm_req         (mm_req),
        .mm_we          (mm_we),
        .mm_addr        (mm_addr),
        .mm_be          (mm_be),
        .mm_wdata       (mm_wdata),
        .mm_rdata       (mm_rdata),
        .mm_ready       (mm_ready)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [29:0] w);
        if (!mem.exists(int'(w))) mem[int'(w)] = $urandom;
        return mem[int'(w)];
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int i;
        i = int'(a[5:2]);
        return line.exists(i) && line[i] == int'(a[31:2]);
    endfunction

    function automatic void model_commit(input logic rd, input logic wr, input logic lb,
                                         input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] w;
        int off;
        off = int'(a[1:0]);
        if (wr) begin
            w = mem_word(a[31:2]);
            if (lb) w[8*off +: 8] = wd[7:0];
            else    w = wd;
            mem[int'(a[31:2])] = w;
        end else if (rd) begin
            line[int'(a[5:2])] = int'(a[31:2]);
        end
    endfunction

    // Presents one access, acts as main memory answering after lat request
    // cycles, and returns what was observed once freeze drops.
    task automatic access(input logic rd, input logic wr, input logic lb,
                          input logic [31:0] a, input logic [31:0] wd, input int lat,
                          output int stall, output logic [31:0] data, output logic [1:0] blk,
                          output logic [31:0] raddr, output logic [3:0] rbe,
                          output logic [31:0] rwdata, output logic rwe);
        int reqs;
        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        is_LB_SB  = lb;
        addr      = a;
        wdata     = wd;
        mm_ready  = 1'b0;
        stall = 0;
        reqs  = 0;
        raddr = '0;
        rbe   = '0;
        rwdata = '0;
        rwe   = 1'b0;
        #1;
        while (freeze === 1'b1 && stall < 40) begin
            stall++;
            if (mm_req === 1'b1) begin
                reqs++;
                raddr  = mm_addr;
                rbe    = mm_be;
                rwdata = mm_wdata;
                rwe    = mm_we;
                if (reqs == lat) begin
                    mm_ready = 1'b1;
                    mm_rdata = mm_we ? 32'h0 : mem_word(mm_addr[31:2]);
                end
            end
            @(negedge clk);
            mm_ready = 1'b0;
            #1;
        end
        data = cache_data_out;
        blk  = mem_block;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_read = 1'b1;
        mem_write = 1'b0;
        is_LB_SB = 1'b0;
        addr = 32'h40;
        wdata = 32'h0;
        mm_ready = 1'b0;
        mm_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (cache_data_out !== 32'h0) $display("FAIL reset_data: got %h want 00000000", cache_data_out); else passed++;
        total++; if (mm_req !== 1'b0) $display("FAIL reset_mm_req: got %b want 0", mm_req); else passed++;
        mem_read = 1'b0;
        #1;
        total++; if (freeze !== 1'b0) $display("FAIL reset_freeze: got %b want 0", freeze); else passed++;
        @(negedge clk);
        rst = 1'b0;
        line.delete();
    endtask

    task automatic test_cold_fill();
        int st; logic [31:0] d, ra, rw; logic [1:0] b; logic [3:0] be; logic we;
        mem[32'h10] = 32'hDEADBEEF;
        access(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 3, st, d, b, ra, be, rw, we);
        total++; if (st !== 4) $display("FAIL cold_stall: got %0d want 4", st); else passed++;
        total++; if (d !== 32'hDEADBEEF) $display("FAIL cold_data: got %h want deadbeef", d); else passed++;
        total++; if (b !== 2'd0) $display("FAIL cold_block: got %0d want 0", b); else passed++;
        total++; if (we !== 1'b0 || be !== 4'b1111 || ra !== 32'h40)
            $display("FAIL cold_req: got we=%b be=%b addr=%h want we=0 be=1111 addr=00000040", we, be, ra);
        else passed++;
        model_commit(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    endtask

    task automatic test_hit_lb();
        int st; logic [31:0] d, ra, rw; logic [1:0] b; logic [3:0] be; logic we;
        access(1'b1, 1'b0, 1'b1, 32'h43, 32'h0, 1, st, d, b, ra, be, rw, we);
        total++; if (st !== 0) $display("FAIL hit_stall: got %0d want 0", st); else passed++;
        total++; if (d !== 32'hDEADBEEF) $display("FAIL hit_data: got %h want deadbeef", d); else passed++;
        total++; if (b !== 2'd3) $display("FAIL hit_block: got %0d want 3", b); else passed++;
`ifdef DCACHE_STATS_EN
        @(negedge clk);
        #1;
        total++; if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1)
            $display("FAIL stats: got hit=%0d miss=%0d want 1 1", hit_cnt, miss_cnt);
        else passed++;
        mem_read = 1'b0;
`endif
    endtask

    task automatic test_store_byte();
        int st; logic [31:0] d, ra, rw; logic [1:0] b; logic [3:0] be; logic we;
        access(1'b0, 1'b1, 1'b1, 32'h41, 32'h55, 2, st, d, b, ra, be, rw, we);
        total++; if (st !== 3) $display("FAIL sb_stall: got %0d want 3", st); else passed++;
        total++; if (be !== 4'b0010) $display("FAIL sb_be: got %b want 0010", be); else passed++;
        total++; if (rw !== 32'h55555555) $display("FAIL sb_wdata: got %h want 55555555", rw); else passed++;
        total++; if (we !== 1'b1 || ra !== 32'h40) $display("FAIL sb_req: got we=%b addr=%h want we=1 addr=00000040", we, ra); else passed++;
        model_commit(1'b0, 1'b1, 1'b1, 32'h41, 32'h55);
        access(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1, st, d, b, ra, be, rw, we);
        total++; if (st !== 0) $display("FAIL sb_readback_stall: got %0d want 0", st); else passed++;
        total++; if (d !== 32'hDEAD55EF) $display("FAIL sb_readback: got %h want dead55ef", d); else passed++;
    endtask

    task automatic test_write_miss();
        int st; logic [31:0] d, ra, rw; logic [1:0] b; logic [3:0] be; logic we;
        access(1'b0, 1'b1, 1'b0, 32'h80, 32'h12345678, 1, st, d, b, ra, be, rw, we);
        total++; if (st !== 2) $display("FAIL sw_miss_stall: got %0d want 2", st); else passed++;
        total++; if (we !== 1'b1 || be !== 4'b1111 || rw !== 32'h12345678 || ra !== 32'h80)
            $display("FAIL sw_miss_req: got we=%b be=%b wdata=%h addr=%h want 1 1111 12345678 00000080", we, be, rw, ra);
        else passed++;
        model_commit(1'b0, 1'b1, 1'b0, 32'h80, 32'h12345678);
        access(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1, st, d, b, ra, be, rw, we);
        total++; if (st !== 0) $display("FAIL sw_miss_line_stall: got %0d want 0", st); else passed++;
        total++; if (d !== 32'hDEAD55EF) $display("FAIL sw_miss_line_data: got %h want dead55ef", d); else passed++;
    endtask

    task automatic test_conflict();
        int st; logic [31:0] d, ra, rw; logic [1:0] b; logic [3:0] be; logic we;
        mem[32'h110] = 32'hCAFEF00D;
        access(1'b1, 1'b0, 1'b0, 32'h440, 32'h0, 2, st, d, b, ra, be, rw, we);
        total++; if (st !== 3) $display("FAIL conflict_stall: got %0d want 3", st); else passed++;
        total++; if (d !== 32'hCAFEF00D) $display("FAIL conflict_data: got %h want cafef00d", d); else passed++;
        model_commit(1'b1, 1'b0, 1'b0, 32'h440, 32'h0);
        access(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1, st, d, b, ra, be, rw, we);
        total++; if (st !== 2) $display("FAIL evicted_stall: got %0d want 2", st); else passed++;
        total++; if (d !== 32'hDEAD55EF) $display("FAIL evicted_data: got %h want dead55ef", d); else passed++;
        model_commit(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    endtask

    task automatic test_reset_mid_fill();
        int st; logic [31:0] d, ra, rw; logic [1:0] b; logic [3:0] be; logic we;
        @(negedge clk);
        mem_read = 1'b1;
        mem_write = 1'b0;
        is_LB_SB = 1'b0;
        addr = 32'h44;
        mm_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (mm_req !== 1'b1) $display("FAIL fill_req: got %b want 1", mm_req); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (mm_req !== 1'b0) $display("FAIL abort_mm_req: got %b want 0", mm_req); else passed++;
        total++; if (cache_data_out !== 32'h0) $display("FAIL abort_data: got %h want 00000000", cache_data_out); else passed++;
        mem_read = 1'b0;
        #1;
        total++; if (freeze !== 1'b0) $display("FAIL abort_freeze: got %b want 0", freeze); else passed++;
        @(negedge clk);
        rst = 1'b0;
        line.delete();
        access(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 1, st, d, b, ra, be, rw, we);
        total++; if (st !== 2) $display("FAIL post_reset_stall: got %0d want 2", st); else passed++;
        total++; if (d !== 32'hDEAD55EF) $display("FAIL post_reset_data: got %h want dead55ef", d); else passed++;
        model_commit(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
    endtask

    task automatic test_back_to_back_random();
        int st, lat, exp_st; logic [31:0] d, ra, rw, a, wd, exp_w; logic [1:0] b; logic [3:0] be, exp_be; logic we;
        logic rd, wr, lb; bit h;
        for (int n = 0; n < 60; n++) begin
            wr  = ($urandom_range(0, 2) == 0);
            rd  = !wr || ($urandom_range(0, 3) == 0);
            lb  = $urandom_range(0, 1) == 1;
            lat = $urandom_range(1, 4);
            a   = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2);
            if (lb) a[1:0] = 2'($urandom_range(0, 3));
            wd  = $urandom;
            h   = model_hit(a);
            exp_st = (wr || !h) ? lat + 1 : 0;
            access(rd, wr, lb, a, wd, lat, st, d, b, ra, be, rw, we);
            total++; if (st !== exp_st) $display("FAIL rnd_stall[%0d]: got %0d want %0d", n, st, exp_st); else passed++;
            total++; if (b !== a[1:0]) $display("FAIL rnd_block[%0d]: got %0d want %0d", n, b, a[1:0]); else passed++;
            if (wr) begin
                exp_be = lb ? (4'b0001 << a[1:0]) : 4'b1111;
                exp_w  = lb ? {4{wd[7:0]}} : wd;
                total++; if (we !== 1'b1 || be !== exp_be || rw !== exp_w || ra !== {a[31:2], 2'b00})
                    $display("FAIL rnd_write[%0d]: got we=%b be=%b wdata=%h addr=%h want 1 %b %h %h",
                             n, we, be, rw, ra, exp_be, exp_w, {a[31:2], 2'b00});
                else passed++;
            end else begin
                exp_w = mem_word(a[31:2]);
                total++; if (d !== exp_w) $display("FAIL rnd_read[%0d]: got %h want %h", n, d, exp_w); else passed++;
            end
            model_commit(rd, wr, lb, a, wd);
        end
    endtask

    initial begin
        test_reset();
        test_cold_fill();
        test_hit_lb();
        test_store_byte();
        test_write_miss();
        test_conflict();
        test_reset_mid_fill();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_stage_dcache.md
Name: mem_stage_dcache

Overview:
- MEM-stage data cache controller, sitting between the EX_to_MEM register and the MEM_to_WB register.
- Direct-mapped, write-through, no-write-allocate cache with one 32-bit word (4 bytes) per line.
- Produces the 4-byte line (`cache_data_out`) and the byte offset (`mem_block`) consumed by the MEM/WB stage.
- Drives `freeze` to stall the pipeline on read misses and on every store until main memory acknowledges.

Parameters:
- NUM_SETS, 16, number of cache lines; power of two, at least 2.
- IDX_W, $clog2(NUM_SETS), index width; derived, never overridden.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_read  in  1  load in MEM stage (LW/LB).
- mem_write  in  1  store in MEM stage (SW/SB).
- is_LB_SB  in  1  byte access when 1, word access when 0.
- addr  in  32  byte address, equal to alu_result.
- wdata  in  32  store data; for SB only wdata[7:0] is used.
- cache_data_out  out  4x8  line bytes [0:3]; byte k = memory byte addr[31:2]*4+k.
- mem_block  out  2  addr[1:0], passed through combinationally.
- freeze  out  1  stall request to every pipeline register.
- mm_req  out  1  main-memory request.
- mm_we  out  1  request is a write.
- mm_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mm_be  out  4  byte enables; 4'b1111 for SW and all reads.
- mm_wdata  out  32  write data; SB replicates the byte into all four lanes.
- mm_rdata  in  32  fill data, valid when mm_ready=1.
- mm_ready  in  1  one-cycle completion pulse.

Behaviour:
- Address split:
  - index = addr[IDX_W+1:2]
  - tag = addr[31:IDX_W+2]
  - hit = valid[index] && tag_arr[index]==tag
- FSM states: IDLE, FILL, WRITE; 2-bit encoding.
- IDLE:
  - Read hit: cache_data_out = data_arr[index] in the same cycle (combinational); freeze=0; 0-cycle penalty.
  - Read miss: freeze=1 combinationally in that cycle; go to FILL.
  - Write (mem_write=1): freeze=1; go to WRITE.
  - On a write hit, update data_arr in the same edge: SW updates all 4 bytes; SB updates byte addr[1:0] only.
  - On a write miss, the array is untouched.
  - mem_read and mem_write both 1: treated as a write.
- FILL:
  - mm_req=1, mm_we=0, mm_be=4'b1111; hold until mm_ready.
  - On the mm_ready edge: data_arr[index]=mm_rdata (byte0 = bits[7:0]), tag updated, valid=1; go to IDLE.
  - freeze stays 1 through the mm_ready cycle; the next IDLE cycle hits and drops freeze.
- WRITE:
  - mm_req=1, mm_we=1; mm_be = SB ? (4'b0001<<addr[1:0]) : 4'b1111.
  - On mm_ready: go to IDLE and freeze=0 in the following cycle.
  - A second store arriving later reuses the path; no posted writes.
- Inputs addr, wdata, is_LB_SB, mem_read and mem_write are stable while freeze=1 (upstream guarantee); the block does not re-sample them.
- mm_req/mm_addr/mm_be/mm_wdata are stable from request assertion until mm_ready.
- mm_ready while in IDLE is ignored.
- Reset, asserted asynchronously, including mid-FILL or mid-WRITE:
  - state=IDLE, all valid bits=0, data and tag arrays cleared, mm_req=0.
  - freeze is combinationally 0 unless a request is present after release.
  - cache_data_out=0 for any access while reset is held.
  - An aborted memory write is lost; the memory model must tolerate a dropped request.
- freeze = (state!=IDLE) || (state==IDLE && (mem_write || (mem_read && !hit))).
- No access (mem_read=mem_write=0): freeze=0; cache_data_out shows data_arr[index] (don't-care downstream).

Optional Feature:
- DCACHE_STATS_EN defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments once per read completed without a stall; miss_cnt increments once per FILL entry.
  - Both counters saturate at 32'hFFFF_FFFF, reset to 0 and are frozen during stalls except for the FILL-entry increment.
- Undefined: ports and counters absent; all other behaviour is identical.

Decomposition:
- Package mem_pkg: dcache_state_t enum {IDLE,FILL,WRITE}, LINE_BYTES=4, a byte-lane typedef, and function sb_be(offset).
- One natural sub-module: dcache_array (valid/tag/data storage with a combinational read port and byte-enable write port, async clear on rst).
- The FSM, freeze logic and memory interface stay in mem_stage_dcache.

Test Plan:
- Cold LW 0x0000_0040, memory returns 0xDEADBEEF after 3 cycles:
  - freeze high for 4 cycles; then cache_data_out={EF,BE,AD,DE}, mem_block=0; miss_cnt=1.
- Repeat LB 0x0000_0043:
  - hit, freeze=0, cache_data_out unchanged, mem_block=3; hit_cnt=1.
- SB 0x0000_0041 wdata=0x55 on that cached line:
  - mm_be=4'b0010, mm_wdata=0x55555555, freeze held until mm_ready.
  - A following LW gives bytes {EF,55,AD,DE} with no stall.
- SW to miss address 0x0000_0080 (index 0, same as 0x40 when NUM_SETS=16):
  - memory write issued; line at index 0 still tagged 0x40 and unchanged.
- Conflict LW 0x0000_0440 (index 0 when NUM_SETS=16, different tag):
  - miss, fill replaces the line; a later LW 0x40 misses again.
- rst pulsed during FILL:
  - mm_req drops immediately, state=IDLE; LW 0x40 afterwards misses (valid cleared).
